// File: rtl/image_encrypter.sv
`default_nettype none
// ============================================================================
//  Module      : image_encrypter
//  Description : Walks a plaintext image in a synchronous ROM byte by byte,
//                encrypts each byte with a keyed LFSR keystream plus
//                ciphertext chaining, and writes it to an image RAM port.
//                Three cycles per byte (ADDR, DATA, WRITE).
//  Revision    : 1.0  initial release
// ============================================================================
module image_encrypter #(
  parameter int ADDR_W    = 15,
  parameter int IMG_BYTES = 19200
) (
  input  logic              clk,
  input  logic              rst,         // asynchronous, active-low
  input  logic              start,
  input  logic [7:0]        key,
  input  logic [7:0]        plain_data,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W-1:0] write_addr,
  output logic [7:0]        cipher_data,
  output logic              write_en,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Terminal index; computed at ADDR_W width so IMG_BYTES == 2**ADDR_W
  // compares against all-ones instead of overflowing.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_BYTES - 1);

  state_t            state_q, state_d;
  // Only the rotate amount of the key is needed after the start edge; the
  // full key seeds the LFSR and the chain register directly at that edge.
  logic [2:0]        key_rot_q, key_rot_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [7:0]        chain_q, chain_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] read_addr_q, read_addr_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [7:0]        cipher_q, cipher_d;

  logic [7:0]        seed;
  logic [7:0]        mixed;
  logic [15:0]       mixed_dbl;
  logic [7:0]        cipher_next;

  // Keystream seed substitution and the per-byte cipher datapath.
  always_comb begin
    seed        = (key == 8'h00) ? 8'hA5 : key;
    mixed       = plain_data ^ lfsr_q;
    mixed_dbl   = {mixed, mixed} << key_rot_q;
    cipher_next = mixed_dbl[15:8] + chain_q;
  end

  // Next-state and datapath updates for the ADDR/DATA/WRITE byte loop.
  always_comb begin
    state_d      = state_q;
    key_rot_d    = key_rot_q;
    lfsr_d       = lfsr_q;
    chain_d      = chain_q;
    index_d      = index_q;
    read_addr_d  = read_addr_q;
    write_addr_d = write_addr_q;
    cipher_d     = cipher_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          key_rot_d   = key[2:0];
          lfsr_d      = seed;
          chain_d     = key;
          index_d     = '0;
          read_addr_d = '0;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        cipher_d     = cipher_next;
        write_addr_d = index_q;
        chain_d      = cipher_next;
        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        state_d      = S_WRITE;
      end
      S_WRITE: begin
        if (index_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          index_d     = index_q + ADDR_W'(1);
          read_addr_d = index_q + ADDR_W'(1);
          state_d     = S_ADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      key_rot_q    <= '0;
      lfsr_q       <= '0;
      chain_q      <= '0;
      index_q      <= '0;
      read_addr_q  <= '0;
      write_addr_q <= '0;
      cipher_q     <= '0;
    end else begin
      state_q      <= state_d;
      key_rot_q    <= key_rot_d;
      lfsr_q       <= lfsr_d;
      chain_q      <= chain_d;
      index_q      <= index_d;
      read_addr_q  <= read_addr_d;
      write_addr_q <= write_addr_d;
      cipher_q     <= cipher_d;
    end
  end

  // Status and strobe outputs decode directly from the state register.
  always_comb begin
    read_addr   = read_addr_q;
    write_addr  = write_addr_q;
    cipher_data = cipher_q;
    write_en    = (state_q == S_WRITE);
    busy        = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_WRITE);
    done        = (state_q == S_DONE);
  end

endmodule
`default_nettype wire
